logic2_pipe: RTL

Parametrised, pipelined successor to the single-bit switch-level AND-OR gate. Each lane computes o = (a | b) & c, or its complement (the internal pull-down node) when `inv` is set, over a WIDTH-bit vector. Data moves through a two-stage elastic pipeline with valid/ready handshakes on both sides. A saturating counter accumulates the number of asserted output bits delivered downstream. The block sits between a producer and a consumer of bit-vector operands and replaces per-bit gate instances in datapath use.

---
 rtl/logic2_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/logic2_pipe.sv
// logic2_pipe: two-stage elastic pipeline of per-lane (a|b)&c gates with
// per-word output inversion and a saturating count of delivered set bits.

// One lane of the gate: the true output, or the pull-down node when inv is set.
module logic2_lane (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic inv,
    output logic y
);
    assign y = inv ? ~((a | b) & c) : ((a | b) & c);
endmodule

module logic2_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ones_cnt
);
    // Popcount width, and a sum width that cannot overflow for any legal
    // WIDTH/CNT_W pairing before saturation is applied.
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((PC_W > CNT_W) ? PC_W : CNT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic             inv;
    } req_t;

    req_t             req_d;
    req_t             s1_q;
    logic [2:1]       vld_pipe;   // [1] = stage-1 valid, [2] = stage-2 valid
    logic             s1_v;
    logic             s2_v;
    logic             accept;
    logic             s2_load;
    logic             deliver;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] o_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_sat;

    assign s1_v    = vld_pipe[1];
    assign s2_v    = vld_pipe[2];
    assign req_d   = '{a: a, b: b, c: c, inv: inv};

    // A slot frees up whenever either stage is empty or the output drains.
    assign in_ready  = rst_n & (~s1_v | ~s2_v | out_ready);
    assign accept    = in_valid & in_ready;
    assign s2_load   = s1_v & (~s2_v | out_ready);
    assign deliver   = s2_v & out_ready;
    assign out_valid = s2_v;
    assign o         = o_q;
    assign ones_cnt  = cnt_q;

    // Per-lane gate evaluation from stage-1 contents, each word with its own inv.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic2_lane u_lane (
            .a   (s1_q.a[i]),
            .b   (s1_q.b[i]),
            .c   (s1_q.c[i]),
            .inv (s1_q.inv),
            .y   (res_d[i])
        );
    end

    // Pipeline valid shift register and stage data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            o_q      <= '0;
        end else begin
            vld_pipe[1] <= accept  | (s1_v & ~s2_load);
            vld_pipe[2] <= s2_load | (s2_v & ~out_ready);
            if (accept)  s1_q <= req_d;
            if (s2_load) o_q  <= res_d;
        end
    end

    // Popcount of the word currently presented on o.
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + PC_W'(o_q[i]);
    end

    // Widened add then clamp to all-ones.
    always_comb begin
        sum     = SUM_W'(cnt_q) + SUM_W'(pc);
        cnt_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    // Delivered-ones counter; clear beats a same-cycle delivery.
    always_ff @(posedge clk) begin
        if (!rst_n)       cnt_q <= '0;
        else if (cnt_clr) cnt_q <= '0;
        else if (deliver) cnt_q <= cnt_sat;
    end
endmodule
